// File: rtl/wb_scratchpad.sv
// wb_scratchpad: Wishbone slave with a DEPTH x 32-bit byte-maskable scratchpad,
// a CTRL register (int_en, int_clr) and a read-only STATUS register
// (write count, interrupt pending). Every transfer walks
// IDLE -> LATCH -> [WAIT] -> ACK -> RELEASE, so exactly one ack is returned per strobe.
// Optional feature macro: WB_SCRATCHPAD_WAIT_EN adds WAIT_CYCLES wait states before each ack.
module wb_scratchpad #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_int_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Reject unsupported configurations at elaboration time.
  if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_scratchpad: DEPTH must be a power of two in 4..4096");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("wb_scratchpad: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
`ifdef WB_SCRATCHPAD_WAIT_EN
    WAIT,
`endif
    ACK,
    RELEASE
  } state_t;

  state_t        state;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   addr_q;
  logic [31:0]   dat_q;
  logic          int_en;
  logic          int_pending;
  logic [15:0]   wcount;
`ifdef WB_SCRATCHPAD_WAIT_EN
  logic [3:0]    wait_cnt;
`endif

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic          is_mem;
  logic          is_ctrl;
  logic          is_stat;
  logic          is_last;
  logic          mem_we;
  logic [31:0]   rd_val;

  assign idx     = addr_q[AW-1:0];
  assign is_mem  = addr_q < 32'(DEPTH);
  assign is_ctrl = addr_q == 32'(DEPTH);
  assign is_stat = addr_q == 32'(DEPTH + 1);
  assign is_last = is_mem && (idx == AW'(DEPTH - 1));
  assign mem_we  = (state == LATCH) && we_q && is_mem;

  // Read mux over the address map, evaluated on the latched address.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rd_val = 32'h0;
    if (is_mem) begin
      rd_val = mem[idx];
    end else if (is_ctrl) begin
      rd_val = {31'h0, int_en};
    end else if (is_stat) begin
      rd_val = {15'h0, int_pending, wcount};
    end
  end

  // Byte-masked scratchpad write, committed in LATCH.
  // NOTE: the storage array has no reset so it can map onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) begin
          mem[idx][8*b +: 8] <= dat_q[8*b +: 8];
        end
      end
    end
  end

  // Transfer FSM with registered ack/data/interrupt and the CTRL/STATUS state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
      state       <= IDLE;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 32'h0;
      wbs_int_o   <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      addr_q      <= 32'h0;
      dat_q       <= 32'h0;
      int_en      <= 1'b0;
      int_pending <= 1'b0;
      wcount      <= 16'h0;
`ifdef WB_SCRATCHPAD_WAIT_EN
      wait_cnt    <= 4'h0;
`endif
    end else begin
      wbs_int_o <= int_pending & int_en;
      case (state)
        IDLE: begin
          wbs_ack_o <= 1'b0;
          if (wbs_cyc_i && wbs_stb_i) begin
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            addr_q <= wbs_adr_i;
            dat_q  <= wbs_dat_i;
            state  <= LATCH;
          end
        end
        LATCH: begin
          if (we_q) begin
            wbs_dat_o <= 32'h0;
            if (is_ctrl) begin
              int_en <= dat_q[0];
              if (dat_q[1]) int_pending <= 1'b0;
            end
            if (is_mem) wcount <= wcount + 16'd1;
            // Placed after the clear so a simultaneous set wins.
            if (is_last) int_pending <= 1'b1;
          end else begin
            wbs_dat_o <= rd_val;
          end
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else begin
`ifdef WB_SCRATCHPAD_WAIT_EN
            if (WAIT_CYCLES > 0) begin
              wait_cnt <= 4'(WAIT_CYCLES);
              state    <= WAIT;
            end else begin
              wbs_ack_o <= 1'b1;
              state     <= ACK;
            end
`else
            wbs_ack_o <= 1'b1;
            state     <= ACK;
`endif
          end
        end
`ifdef WB_SCRATCHPAD_WAIT_EN
        WAIT: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else if (wait_cnt <= 4'd1) begin
            wbs_ack_o <= 1'b1;
            state     <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`endif
        ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= wbs_cyc_i ? RELEASE : IDLE;
        end
        RELEASE: begin
          wbs_ack_o <= 1'b0;
          if (!wbs_stb_i || !wbs_cyc_i) state <= IDLE;
        end
        default: begin
          wbs_ack_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_scratchpad.sv
// Directed bench for wb_scratchpad: read expectations go through a scoreboard
// queue when a read is issued and are popped when the ack arrives.
module tb_wb_scratchpad;

  localparam int unsigned DEPTH       = 16;
  localparam int unsigned WAIT_CYCLES = 3;
`ifdef WB_SCRATCHPAD_WAIT_EN
  localparam int EXP_LAT = 3 + WAIT_CYCLES;
`else
  localparam int EXP_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] dat_i = 32'h0;
  logic [31:0] dat_o;
  logic        ack;
  logic        irq;

  int          errors = 0;
  int          checks = 0;
  int          last_lat = 0;
  logic [31:0] exp_q[$];

  wb_scratchpad #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_we_i  (we),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_dat_o (dat_o),
    .wbs_ack_o (ack),
    .wbs_int_o (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transfer; reads push their expected data, popped at ack.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e, input string tag);
    int  n;
    bit  got;
    @(negedge clk);
    we = w; adr = a; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    if (!w) exp_q.push_back(e);
    got = 1'b0;
    n   = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (ack === 1'b1) got = 1'b1;
    end
    last_lat = n + 1;
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed no ack after %0d cycles expected ack", tag, n);
      if (!w) void'(exp_q.pop_front());
    end else if (!w) begin
      check(tag, dat_o, exp_q.pop_front());
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    int acks;
    int n;

    // Reset held for 5 clocks.
    repeat (5) @(negedge clk);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_int", {31'h0, irq}, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    rst = 1'b1;
    xfer(1'b0, DEPTH + 1, 32'h0, 4'hF, 32'h0, "status_after_reset");

    // Byte-masked writes.
    xfer(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 32'h0, "wr5_full");
    xfer(1'b1, 32'd5, 32'h00000011, 4'h1, 32'h0, "wr5_lane0");
    xfer(1'b0, 32'd5, 32'h0, 4'hF, 32'hDEADBE11, "rd5_merged");
    check("latency", last_lat, EXP_LAT);
    xfer(1'b0, DEPTH + 1, 32'h0, 4'hF, 32'h0000_0002, "status_wcount2");

    // Interrupt set by the last word, cleared through CTRL bit1.
    xfer(1'b1, DEPTH, 32'h1, 4'hF, 32'h0, "ctrl_en");
    xfer(1'b1, DEPTH - 1, 32'h1, 4'hF, 32'h0, "wr_last");
    n = 0;
    while (irq !== 1'b1 && n < 2) begin
      @(negedge clk);
      n++;
    end
    check("int_set", {31'h0, irq}, 32'h1);
    xfer(1'b0, DEPTH + 1, 32'h0, 4'hF, 32'h0001_0003, "status_pending");
    xfer(1'b1, DEPTH, 32'h3, 4'hF, 32'h0, "ctrl_clr");
    repeat (2) @(negedge clk);
    check("int_clr", {31'h0, irq}, 32'h0);
    xfer(1'b0, DEPTH + 1, 32'h0, 4'hF, 32'h0000_0003, "status_cleared");
    xfer(1'b0, DEPTH, 32'h0, 4'hF, 32'h0000_0001, "ctrl_readback");

    // Unmapped write with strobe held for 10 clocks: exactly one ack.
    @(negedge clk);
    we = 1'b1; adr = DEPTH + 7; dat_i = 32'h12345678; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("held_stb_acks", acks, 1);
    xfer(1'b0, DEPTH + 7, 32'h0, 4'hF, 32'h0, "rd_unmapped");
    xfer(1'b0, DEPTH + 1, 32'h0, 4'hF, 32'h0000_0003, "status_unmapped_nocount");

    // Abort: cyc dropped the cycle after the strobe sample.
    @(negedge clk);
    we = 1'b0; adr = 32'd5; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    check("abort_acks", acks, 0);
    xfer(1'b0, 32'd5, 32'h0, 4'hF, 32'hDEADBE11, "rd5_after_abort");

    // sel=0000 write: data unchanged, count still advances.
    xfer(1'b1, 32'd5, 32'hFFFFFFFF, 4'h0, 32'h0, "wr5_nosel");
    xfer(1'b0, 32'd5, 32'h0, 4'hF, 32'hDEADBE11, "rd5_nosel");
    xfer(1'b0, DEPTH + 1, 32'h0, 4'hF, 32'h0000_0004, "status_wcount4");

    // Reset mid-transfer: ack drops at once, scratchpad contents survive.
    @(negedge clk);
    we = 1'b0; adr = 32'd5; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    repeat (EXP_LAT - 1) @(negedge clk);
    check("ack_before_rst", {31'h0, ack}, 32'h1);
    rst = 1'b0;
    #1;
    check("ack_async_drop", {31'h0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    xfer(1'b0, 32'd5, 32'h0, 4'hF, 32'hDEADBE11, "rd5_after_rst");
    xfer(1'b0, DEPTH + 1, 32'h0, 4'hF, 32'h0, "status_after_rst");
    xfer(1'b0, DEPTH, 32'h0, 4'hF, 32'h0, "ctrl_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
